// File: rtl/dffr.sv
// Rising-edge D flip-flop with asynchronous active-high reset and complementary outputs.
// Used per bit to build registers, counters and state machines.
module dffr #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qbar
);

  logic s_q;
  logic s_d;

  assign s_d = d;

  // Reset wins over any coincident clock edge and holds for as long as rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= RESET_VALUE;
    end else begin
      s_q <= s_d;
    end
  end

  assign q    = s_q;
  assign qbar = ~s_q;

endmodule

// File: tb/tb_dffr.sv
// Scoreboard bench for dffr: default-reset and reset-to-one instances are driven by a shared stimulus.
module tb_dffr;

  logic clk;
  logic rst;
  logic d;
  logic q0, qbar0;
  logic q1, qbar1;

  dffr u_dut0 (.clk(clk), .rst(rst), .d(d), .q(q0), .qbar(qbar0));
  dffr #(.RESET_VALUE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .d(d), .q(q1), .qbar(qbar1));

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  logic m_s0;
  logic m_s1;
  int n_total;
  int n_bad;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag);
    sb_entry_t e;
    e.tag = tag;
    e.exp = {m_s0, ~m_s0, m_s1, ~m_s1};
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    sb_entry_t e;
    if (sb.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_empty got=0 exp=1 t=%0t", $time);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".q0"},    q0,    e.exp[3]);
    chk({e.tag, ".qbar0"}, qbar0, e.exp[2]);
    chk({e.tag, ".q1"},    q1,    e.exp[1]);
    chk({e.tag, ".qbar1"}, qbar1, e.exp[0]);
  endtask

  task automatic model_reset();
    m_s0 = 1'b0;
    m_s1 = 1'b1;
  endtask

  task automatic model_capture(input logic dv);
    m_s0 = dv;
    m_s1 = dv;
  endtask

  // Expectation queued before the edge, checked 1 time unit after it.
  task automatic edge_check(input string tag);
    sb_push(tag);
    @(posedge clk);
    #1;
    sb_pop();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    d   = 1'b0;
    model_reset();
    #1;
    sb_push("reset_t1");
    sb_pop();

    // Reset hold across rising edges 10..90
    for (int i = 0; i < 5; i++) edge_check("reset_hold");
    @(negedge clk);

    // t=100: release and capture 1 on the 110 edge
    rst = 1'b0;
    d   = 1'b1;
    sb_push("release_hold");
    #5;
    sb_pop();
    model_capture(1'b1);
    edge_check("capture1");

    repeat (5) @(negedge clk);
    d = 1'b0;
    sb_push("hold_before_210");
    #5;
    sb_pop();
    model_capture(1'b0);
    edge_check("capture0");

    repeat (5) @(negedge clk);
    d = 1'b1;
    model_capture(1'b1);
    edge_check("capture1_again");

    // t=315: asynchronous reset during the high phase
    #4;
    rst = 1'b1;
    model_reset();
    sb_push("async_rst_high");
    #1;
    sb_pop();
    edge_check("rst_hold_330");
    edge_check("rst_hold_350");

    // Release on a falling edge; state holds until the next rising edge
    @(negedge clk);
    rst = 1'b0;
    d   = 1'b0;
    sb_push("post_release_hold");
    #5;
    sb_pop();
    model_capture(1'b0);
    edge_check("post_release_cap");

    // d pulse between rising edges must not be captured
    #4;
    d = 1'b1;
    sb_push("glitch_mid");
    #1;
    sb_pop();
    #4;
    d = 1'b0;
    edge_check("glitch_edge");

    // Random data
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d = 1'($urandom_range(0, 1));
      model_capture(d);
      edge_check("rand");
    end

    // Asynchronous reset during the low phase with q = 1
    @(negedge clk);
    d = 1'b1;
    model_capture(1'b1);
    edge_check("pre_low_rst");
    @(negedge clk);
    #5;
    rst = 1'b1;
    model_reset();
    sb_push("async_rst_low");
    #1;
    sb_pop();
    @(negedge clk);
    rst = 1'b0;
    d   = 1'b0;
    model_capture(1'b0);
    edge_check("final_cap");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
